hangman_datapath: RTL and testbench

Datapath for the Blind Hangman game, driven by `controller`. It holds the secret word, the current guess, the remaining-tries counter, the guessed-letter mask and the win/lose flags. It applies the controller's select/enable strobes each clock and returns the status signals `input_char_eq_word` and `guessed_letters_is_done`. The block sits between the character-input front end (keyboard/Wishbone) and the display logic.

---
 rtl/hangman_pkg.sv | 29 ++
 rtl/hangman_word_rom.sv | 26 ++
 rtl/hangman_datapath.sv | 140 ++++++++++++++
 tb/tb_hangman_datapath.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the Blind Hangman datapath: letter encoding, word
// geometry, guessed-mask operation codes and the packed word type.
package hangman_pkg;

    localparam int unsigned LETTER_W  = 5;
    localparam int unsigned WORD_LEN  = 5;
    localparam int unsigned MAX_TRIES = 7;
    localparam int unsigned NUM_WORDS = 8;

    // a=0 ... z=25; this code never matches a word letter
    localparam logic [LETTER_W-1:0] LETTER_NONE = 5'd31;

    // Mask op codes; 1..WORD_LEN set bit (op-1)
    localparam logic [2:0] GL_CLEAR    = 3'd0;
    localparam logic [2:0] GL_OR_MATCH = 3'd6;
    localparam logic [2:0] GL_HOLD     = 3'd7;

    // Element [WORD_LEN-1] is the leftmost letter (position 0)
    typedef logic [WORD_LEN-1:0][LETTER_W-1:0] word_t;

    function automatic word_t pack_word(input logic [LETTER_W-1:0] l0,
                                        input logic [LETTER_W-1:0] l1,
                                        input logic [LETTER_W-1:0] l2,
                                        input logic [LETTER_W-1:0] l3,
                                        input logic [LETTER_W-1:0] l4);
        return {l0, l1, l2, l3, l4};
    endfunction

endpackage

// File: rtl/hangman_word_rom.sv
// Combinational secret-word ROM.
//   index : word number, 0 .. NUM_WORDS-1
//   word  : packed word, leftmost letter in the MSBs
module hangman_word_rom
    import hangman_pkg::*;
(
    input  logic [$clog2(NUM_WORDS)-1:0] index,
    output word_t                        word
);

    always_comb begin
        word = pack_word(5'd13, 5'd14, 5'd19, 5'd17, 5'd4);          // notre
        case (index)
            3'd0: word = pack_word(5'd13, 5'd14, 5'd19, 5'd17, 5'd4);  // notre
            3'd1: word = pack_word(5'd2,  5'd17, 5'd0,  5'd13, 5'd4);  // crane
            3'd2: word = pack_word(5'd15, 5'd11, 5'd20, 5'd12, 5'd1);  // plumb
            3'd3: word = pack_word(5'd6,  5'd7,  5'd14, 5'd18, 5'd19); // ghost
            3'd4: word = pack_word(5'd21, 5'd8,  5'd23, 5'd4,  5'd13); // vixen
            3'd5: word = pack_word(5'd9,  5'd20, 5'd12, 5'd15, 5'd24); // jumpy
            3'd6: word = pack_word(5'd22, 5'd0,  5'd11, 5'd19, 5'd25); // waltz
            3'd7: word = pack_word(5'd5,  5'd17, 5'd14, 5'd2,  5'd10); // frock
            default: ;
        endcase
    end

endmodule

// File: rtl/hangman_datapath.sv
// Blind Hangman datapath: holds the secret word, the last captured guess,
// the tries counter, the guessed-letter mask and the win/lose flags, and
// applies the controller strobes every clock.
//   clk, reset               : clock, synchronous active-high reset
//   s_*/en_*                 : controller selects and enables
//   char_in/char_valid       : guess from the input front end
//   char_ack                 : registered one-cycle capture pulse
//   input_char_eq_word       : per-position match (MSB = leftmost letter)
//   guessed_letters_is_done  : every mask bit set
//   tries_is_zero, tries     : remaining tries
//   guessed_mask, win, lose  : game state for the display
module hangman_datapath
    import hangman_pkg::*;
#(
    parameter int unsigned LETTER_W  = hangman_pkg::LETTER_W,
    parameter int unsigned WORD_LEN  = hangman_pkg::WORD_LEN,
    parameter int unsigned MAX_TRIES = hangman_pkg::MAX_TRIES,
    parameter int unsigned NUM_WORDS = hangman_pkg::NUM_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tries,
    input  logic                en_tries,
    input  logic [2:0]          s_guessed_letters,
    input  logic                en_guessed_letters,
    input  logic                en_word_index,
    input  logic                en_input_char,
    input  logic                s_win,
    input  logic                en_win,
    input  logic                s_lose,
    input  logic                en_lose,
    input  logic [LETTER_W-1:0] char_in,
    input  logic                char_valid,
    output logic                char_ack,
    output logic [WORD_LEN-1:0] input_char_eq_word,
    output logic                guessed_letters_is_done,
    output logic                tries_is_zero,
    output logic [2:0]          tries,
    output logic [WORD_LEN-1:0] guessed_mask,
    output logic                win,
    output logic                lose
);

    localparam int unsigned IdxW = $clog2(NUM_WORDS);

    logic [IdxW-1:0]                    word_index_q, word_index_d, rom_addr;
    word_t                              rom_word;
    logic [WORD_LEN-1:0][LETTER_W-1:0]  word_q, word_d;
    logic [LETTER_W-1:0]                input_char_q, input_char_d;
    logic [2:0]                         tries_q, tries_d;
    logic [WORD_LEN-1:0]                mask_q, mask_d;
    logic                               win_q, win_d, lose_q, lose_d;
    logic                               char_ack_q, char_ack_d;
    logic [WORD_LEN-1:0]                match;

    // Under reset the ROM is addressed at 0 so the word register reloads rom[0]
    assign rom_addr = reset ? '0 : word_index_q + IdxW'(1);

    hangman_word_rom u_rom (
        .index (rom_addr),
        .word  (rom_word)
    );

    always_comb begin
        for (int unsigned i = 0; i < WORD_LEN; i++) begin
            match[i] = (input_char_q != LETTER_NONE) && (input_char_q == word_q[i]);
        end
    end

    always_comb begin
        word_index_d = word_index_q;
        word_d       = word_q;
        if (en_word_index) begin
            word_index_d = word_index_q + IdxW'(1);
            word_d       = rom_word;
        end

        char_ack_d   = en_input_char && char_valid;
        input_char_d = char_ack_d ? char_in : input_char_q;

        tries_d = tries_q;
        if (en_tries) begin
            if (s_tries) begin
                tries_d = 3'(MAX_TRIES);
            end else if (tries_q != 3'd0) begin
                tries_d = tries_q - 3'd1;
            end
        end

        // OR uses the match of the current registers, i.e. the old guess/word
        mask_d = mask_q;
        if (en_guessed_letters) begin
            case (s_guessed_letters)
                GL_CLEAR:    mask_d = '0;
                GL_OR_MATCH: mask_d = mask_q | match;
                GL_HOLD:     mask_d = mask_q;
                default: begin
                    for (int unsigned i = 0; i < WORD_LEN; i++) begin
                        if (s_guessed_letters == 3'(i + 1)) mask_d[i] = 1'b1;
                    end
                end
            endcase
        end

        win_d  = en_win  ? s_win  : win_q;
        lose_d = en_lose ? s_lose : lose_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_index_q <= '0;
            word_q       <= rom_word;
            input_char_q <= LETTER_NONE;
            tries_q      <= 3'(MAX_TRIES);
            mask_q       <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            char_ack_q   <= 1'b0;
        end else begin
            word_index_q <= word_index_d;
            word_q       <= word_d;
            input_char_q <= input_char_d;
            tries_q      <= tries_d;
            mask_q       <= mask_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            char_ack_q   <= char_ack_d;
        end
    end

    assign char_ack                = char_ack_q;
    assign input_char_eq_word      = match;
    assign guessed_letters_is_done = &mask_q;
    assign tries_is_zero           = (tries_q == 3'd0);
    assign tries                   = tries_q;
    assign guessed_mask            = mask_q;
    assign win                     = win_q;
    assign lose                    = lose_q;

endmodule

// File: tb/tb_hangman_datapath.sv
// Scoreboard bench for hangman_datapath: each stimulus cycle pushes the
// expected post-edge output snapshot; a monitor on the falling edge pops and
// compares it against the DUT.
module tb_hangman_datapath;

    logic       clk = 1'b0;
    logic       reset, s_tries, en_tries, en_guessed_letters, en_word_index;
    logic       en_input_char, s_win, en_win, s_lose, en_lose, char_valid;
    logic [2:0] s_guessed_letters;
    logic [4:0] char_in;
    logic       char_ack, guessed_letters_is_done, tries_is_zero, win, lose;
    logic [4:0] input_char_eq_word, guessed_mask;
    logic [2:0] tries;

    hangman_datapath dut (
        .clk                     (clk),
        .reset                   (reset),
        .s_tries                 (s_tries),
        .en_tries                (en_tries),
        .s_guessed_letters       (s_guessed_letters),
        .en_guessed_letters      (en_guessed_letters),
        .en_word_index           (en_word_index),
        .en_input_char           (en_input_char),
        .s_win                   (s_win),
        .en_win                  (en_win),
        .s_lose                  (s_lose),
        .en_lose                 (en_lose),
        .char_in                 (char_in),
        .char_valid              (char_valid),
        .char_ack                (char_ack),
        .input_char_eq_word      (input_char_eq_word),
        .guessed_letters_is_done (guessed_letters_is_done),
        .tries_is_zero           (tries_is_zero),
        .tries                   (tries),
        .guessed_mask            (guessed_mask),
        .win                     (win),
        .lose                    (lose)
    );

    always #5 clk = ~clk;

    // Snapshot: {ack, eq[4:0], done, tz, tries[2:0], mask[4:0], win, lose}
    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] act;

    assign act = {char_ack, input_char_eq_word, guessed_letters_is_done, tries_is_zero,
                  tries, guessed_mask, win, lose};

    // Hand-maintained expected state
    logic       e_ack, e_win, e_lose;
    logic [4:0] e_eq, e_mask;
    logic [2:0] e_tries;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got ack=%b eq=%b done=%b tz=%b tries=%0d mask=%b win=%b lose=%b, expected ack=%b eq=%b done=%b tz=%b tries=%0d mask=%b win=%b lose=%b",
                         e.name, act[17], act[16:12], act[11], act[10], act[9:7], act[6:2],
                         act[1], act[0], e.v[17], e.v[16:12], e.v[11], e.v[10], e.v[9:7],
                         e.v[6:2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic idle_inputs();
        reset = 1'b0; s_tries = 1'b0; en_tries = 1'b0; s_guessed_letters = 3'd7;
        en_guessed_letters = 1'b0; en_word_index = 1'b0; en_input_char = 1'b0;
        s_win = 1'b0; en_win = 1'b0; s_lose = 1'b0; en_lose = 1'b0; char_valid = 1'b0;
    endtask

    // One clock edge with the current inputs; queue what must hold after it
    task automatic tick(input string name);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.v = {e_ack, e_eq, &e_mask, (e_tries == 3'd0), e_tries, e_mask, e_win, e_lose};
        sb_q.push_back(e);
        e_ack = 1'b0;
        #1;
        idle_inputs();
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        e_ack = 1'b0; e_eq = 5'b0; e_mask = 5'b0; e_tries = 3'd7; e_win = 1'b0; e_lose = 1'b0;
        tick(name);
    endtask

    task automatic guess(input logic [4:0] c, input logic [4:0] v, input string name);
        char_in = c; char_valid = 1'b1; en_input_char = 1'b1;
        e_ack = 1'b1; e_eq = v;
        tick(name);
    endtask

    task automatic or_match(input string name);
        en_guessed_letters = 1'b1; s_guessed_letters = 3'd6;
        e_mask = e_mask | e_eq;
        tick(name);
    endtask

    task automatic miss_dec(input string name);
        guess(5'd25, 5'b00000, "miss_capture");
        en_tries = 1'b1; s_tries = 1'b0;
        e_tries = (e_tries == 3'd0) ? 3'd0 : e_tries - 3'd1;
        tick(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        char_in = 5'd0;

        // Reset state
        do_reset("reset");
        tick("reset_idle");

        // Win path on "notre"
        guess(5'd13, 5'b10000, "cap_n"); or_match("or_n");
        guess(5'd14, 5'b01000, "cap_o"); or_match("or_o");
        guess(5'd19, 5'b00100, "cap_t"); or_match("or_t");
        guess(5'd17, 5'b00010, "cap_r"); or_match("or_r");
        guess(5'd4,  5'b00001, "cap_e"); or_match("or_e_done");
        en_win = 1'b1; s_win = 1'b1; e_win = 1'b1;
        tick("win_set");

        // Lose path
        do_reset("reset_lose");
        repeat (7) miss_dec("miss_dec");
        miss_dec("dec_at_zero");
        en_lose = 1'b1; s_lose = 1'b1; e_lose = 1'b1;
        tick("lose_set");
        en_tries = 1'b1; s_tries = 1'b1; e_tries = 3'd7;
        tick("tries_reload");
        en_lose = 1'b1; s_lose = 1'b0; e_lose = 1'b0;
        tick("lose_clear");

        // Handshake
        do_reset("reset_hs");
        guess(5'd14, 5'b01000, "hs_cap_o");
        en_input_char = 1'b1; char_valid = 1'b0; char_in = 5'd13;
        tick("hs_no_valid");
        guess(5'd13, 5'b10000, "hs_valid_ack");
        tick("hs_ack_drop");
        guess(5'd19, 5'b00100, "hs_held_1");
        guess(5'd17, 5'b00010, "hs_held_2");
        // Capture and OR at the same edge: OR sees the old guess (r)
        char_in = 5'd4; char_valid = 1'b1; en_input_char = 1'b1;
        en_guessed_letters = 1'b1; s_guessed_letters = 3'd6;
        e_mask = e_mask | e_eq; e_eq = 5'b00001; e_ack = 1'b1;
        tick("hs_cap_and_or");
        tick("hs_idle");

        // Word index wrap and mask ops
        do_reset("reset_word");
        for (int i = 0; i < 9; i++) begin
            en_word_index = 1'b1;
            tick("word_adv");
        end
        guess(5'd2,  5'b10000, "crane_c");
        guess(5'd0,  5'b00100, "crane_a");
        guess(5'd13, 5'b00010, "crane_n");
        en_word_index = 1'b1; e_eq = 5'b00000;
        tick("word_plumb");
        guess(5'd20, 5'b00100, "plumb_u");
        // Word load and OR at the same edge: OR compares against plumb
        en_word_index = 1'b1; en_guessed_letters = 1'b1; s_guessed_letters = 3'd6;
        e_mask = e_mask | e_eq; e_eq = 5'b00000;
        tick("word_ghost_or");
        for (int k = 1; k <= 5; k++) begin
            en_guessed_letters = 1'b1; s_guessed_letters = 3'(k);
            e_mask[k-1] = 1'b1;
            tick("mask_set_bit");
        end
        en_guessed_letters = 1'b1; s_guessed_letters = 3'd7;
        tick("mask_hold");
        en_guessed_letters = 1'b1; s_guessed_letters = 3'd0; e_mask = 5'b0;
        tick("mask_clear");

        // Reset mid-game with competing strobes
        do_reset("reset_mid_pre");
        repeat (3) miss_dec("mid_miss");
        guess(5'd13, 5'b10000, "mid_cap_n"); or_match("mid_or_n");
        guess(5'd14, 5'b01000, "mid_cap_o"); or_match("mid_or_o");
        en_lose = 1'b1; s_lose = 1'b1; e_lose = 1'b1;
        tick("mid_lose");
        en_win = 1'b1; s_win = 1'b1; e_win = 1'b1;
        tick("mid_win_both");
        en_input_char = 1'b1; char_valid = 1'b1; char_in = 5'd19;
        en_tries = 1'b1; s_tries = 1'b0;
        en_guessed_letters = 1'b1; s_guessed_letters = 3'd6;
        en_word_index = 1'b1; en_win = 1'b1; s_win = 1'b1;
        do_reset("reset_mid");
        guess(5'd13, 5'b10000, "post_reset_notre");

        repeat (2) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
